// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared types and colour constants for the VGA test-pattern generator
// Contents: tpg_pattern_e (run-time pattern select), WHITE/BLACK, TPG_BAR_COLORS.
// Colours are packed {b,g,r}, 4 bits per channel.
package vga_pkg;

  typedef enum logic [1:0] {
    TPG_SOLID   = 2'd0,
    TPG_BARS    = 2'd1,
    TPG_CHECKER = 2'd2,
    TPG_RAMP    = 2'd3
  } tpg_pattern_e;

  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] BLACK = 12'h000;

  // Left-to-right bar order: white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [0:7][11:0] TPG_BAR_COLORS = {
    12'hFFF, 12'h0FF, 12'hFF0, 12'h0F0,
    12'hF0F, 12'h00F, 12'hF00, 12'h000
  };

endpackage

// File: rtl/vga_tpg_if.sv
// rtl/vga_tpg_if.sv - AXI4-Stream style pixel channel between the generator and the VGA output stage
// Signals: tvalid, tready, tdata {b,g,r} 3x4 bits, tlast (end of line), tuser (start of frame).
// Modports: master (generator side), slave (output-stage side).
interface vga_tpg_if;

  logic            tvalid;
  logic            tready;
  logic [2:0][3:0] tdata;
  logic            tlast;
  logic            tuser;

  modport master (
    output tvalid,
    output tdata,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tvalid,
    input  tdata,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface

// File: rtl/vga_tpg_xy_cnt.sv
// rtl/vga_tpg_xy_cnt.sv - raster position and completed-frame counters for the test-pattern generator
// Ports:
//   aclk, areset     clock, synchronous active-high reset
//   adv              a pixel was accepted this cycle; step to the next raster position
//   x_nxt, y_nxt     coordinates the counters take on at this edge (pixel to be loaded)
//   fc_nxt           frame count that goes with x_nxt/y_nxt
//   last_nxt         x_nxt is the last pixel of its line
//   first_nxt        x_nxt/y_nxt is the first pixel of the frame
//   frame_cnt        completed-frame counter, wraps 255 -> 0
module vga_tpg_xy_cnt #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  localparam int XW = $clog2(H_RES),
  localparam int YW = $clog2(V_RES)
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          adv,
  output logic [XW-1:0] x_nxt,
  output logic [YW-1:0] y_nxt,
  output logic [7:0]    fc_nxt,
  output logic          last_nxt,
  output logic          first_nxt,
  output logic [7:0]    frame_cnt
);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          eol;
  logic          eof;

  // The next-state values are exported because the output register must be
  // loaded with the pixel at the position being advanced to, not the current one.
  always_comb begin
    x_nxt  = x;
    y_nxt  = y;
    fc_nxt = frame_cnt;
    eol    = (x == XW'(H_RES - 1));
    eof    = eol && (y == YW'(V_RES - 1));
    if (adv) begin
      if (eol) begin
        x_nxt = '0;
        y_nxt = (y == YW'(V_RES - 1)) ? '0 : y + 1'b1;
        if (eof) begin
          fc_nxt = frame_cnt + 8'd1;
        end
      end else begin
        x_nxt = x + 1'b1;
      end
    end
    last_nxt  = (x_nxt == XW'(H_RES - 1));
    first_nxt = (x_nxt == '0) && (y_nxt == '0);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      x         <= '0;
      y         <= '0;
      frame_cnt <= '0;
    end else begin
      x         <= x_nxt;
      y         <= y_nxt;
      frame_cnt <= fc_nxt;
    end
  end

endmodule

// File: rtl/vga_tpg.sv
// rtl/vga_tpg.sv - AXI4-Stream video test-pattern generator (solid, colour bars, checkerboard, moving ramp)
// Ports:
//   aclk, areset     clock, synchronous active-high reset
//   pattern_sel      0 solid, 1 colour bars, 2 checkerboard, 3 moving ramp (taken at frame start)
//   solid_color      {b,g,r} colour for the solid pattern (taken at frame start)
//   pix              vga_tpg_if.master pixel stream (tvalid/tready/tdata/tlast/tuser)
//   frame_cnt        completed-frame counter, wraps 255 -> 0
// Build option: define VGA_TPG_BORDER_EN to force a one-pixel white border over every pattern.
module vga_tpg
  import vga_pkg::*;
#(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int CHECK_LOG2 = 5
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] solid_color,
  vga_tpg_if.master   pix,
  output logic [7:0]  frame_cnt
);

  localparam int XW    = $clog2(H_RES);
  localparam int YW    = $clog2(V_RES);
  localparam int BAR_W = H_RES / 8;

  logic          adv;
  logic          load;
  logic [XW-1:0] x_nxt;
  logic [YW-1:0] y_nxt;
  logic [7:0]    fc_nxt;
  logic          last_nxt;
  logic          first_nxt;

  tpg_pattern_e  pat_q;
  tpg_pattern_e  pat_cur;
  logic [11:0]   solid_q;
  logic [11:0]   solid_cur;
  logic [2:0]    bar_idx;
  logic          chk;
  logic [5:0]    ramp_sum;
  logic [11:0]   pix_nxt;

  // adv: a beat is accepted. load: the output register takes a new pixel,
  // either after an accept or on the first cycle out of reset (tvalid still 0).
  assign adv  = pix.tvalid && pix.tready;
  assign load = !pix.tvalid || pix.tready;

  vga_tpg_xy_cnt #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_xy_cnt (
    .aclk      (aclk),
    .areset    (areset),
    .adv       (adv),
    .x_nxt     (x_nxt),
    .y_nxt     (y_nxt),
    .fc_nxt    (fc_nxt),
    .last_nxt  (last_nxt),
    .first_nxt (first_nxt),
    .frame_cnt (frame_cnt)
  );

  // The SOF pixel itself must already use the newly selected pattern, so the
  // live inputs are used directly while it is being loaded.
  always_comb begin
    pat_cur   = pat_q;
    solid_cur = solid_q;
    if (first_nxt) begin
      pat_cur   = tpg_pattern_e'(pattern_sel);
      solid_cur = solid_color;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      pat_q   <= TPG_SOLID;
      solid_q <= '0;
    end else if (load && first_nxt) begin
      pat_q   <= pat_cur;
      solid_q <= solid_cur;
    end
  end

  // Bar index by thresholds instead of x / BAR_W.
  always_comb begin
    bar_idx = '0;
    for (int i = 1; i < 8; i++) begin
      if (32'(x_nxt) >= i * BAR_W) begin
        bar_idx = 3'(i);
      end
    end
  end

  // Coordinates are widened before bit selection so small rasters still yield
  // the zero bits a full-width counter would have there.
  always_comb begin
    chk      = 1'((32'(x_nxt) ^ 32'(y_nxt)) >> CHECK_LOG2);
    ramp_sum = 6'(x_nxt) + fc_nxt[5:0];
    pix_nxt  = BLACK;
    case (pat_cur)
      TPG_SOLID:   pix_nxt = solid_cur;
      TPG_BARS:    pix_nxt = TPG_BAR_COLORS[bar_idx];
      TPG_CHECKER: pix_nxt = chk ? WHITE : BLACK;
      TPG_RAMP:    pix_nxt = {fc_nxt[7:4], 4'(6'(y_nxt) >> 2), 4'(ramp_sum >> 2)};
      default:     pix_nxt = BLACK;
    endcase
`ifdef VGA_TPG_BORDER_EN
    if ((x_nxt == '0) || (x_nxt == XW'(H_RES - 1)) ||
        (y_nxt == '0) || (y_nxt == YW'(V_RES - 1))) begin
      pix_nxt = WHITE;
    end
`else
`endif
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      pix.tvalid <= 1'b0;
      pix.tdata  <= '0;
      pix.tlast  <= 1'b0;
      pix.tuser  <= 1'b0;
    end else if (load) begin
      pix.tvalid <= 1'b1;
      pix.tdata  <= pix_nxt;
      pix.tlast  <= last_nxt;
      pix.tuser  <= first_nxt;
    end
  end

endmodule
